// File: rtl/camera_fifo_burst_reader_pkg.sv
// Shared types and helpers for the camera FIFO read-side burst engine.
package camera_fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam int CMD_LEN_W = 8;

    function automatic int burst_bytes(input int burst_len, input int data_width);
        return burst_len * (data_width / 8);
    endfunction

endpackage

// File: rtl/camera_fifo_burst_reader_if.sv
// FIFO read port plus DDR write-command / write-data channels of the burst reader.
interface camera_fifo_burst_reader_if
    import camera_fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int ADDR_WIDTH  = 28
);
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic [DEPTH_WIDTH:0]  fifo_rd_water_level;
    logic                  fifo_rd_en;

    logic                  wr_cmd_valid;
    logic                  wr_cmd_ready;
    logic [ADDR_WIDTH-1:0] wr_cmd_addr;
    logic [CMD_LEN_W-1:0]  wr_cmd_len;

    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_data_last;

    modport master (
        input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, wr_cmd_ready, wr_data_ready,
        output fifo_rd_en, wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_data_valid, wr_data,
               wr_data_last
    );

    modport slave (
        output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, wr_cmd_ready, wr_data_ready,
        input  fifo_rd_en, wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_data_valid, wr_data,
               wr_data_last
    );
endinterface

// File: rtl/camera_fifo_burst_reader_skid_buf.sv
// Two-entry skid FIFO that absorbs the one-cycle FIFO read latency under backpressure.
module camera_fifo_burst_reader_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/camera_fifo_burst_reader.sv
// Drains full bursts from the camera FIFO into the frame buffer: one write command, then BURST_LEN beats.
module camera_fifo_burst_reader
    import camera_fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int BURST_LEN   = 16,
    parameter int ADDR_WIDTH  = 28,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_BYTES = 1572864
) (
    input  logic                        rd_clk,
    input  logic                        rd_rst,
    input  logic                        frame_start,
    output logic                        frame_done,
    camera_fifo_burst_reader_if.master  bus
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]      BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [DEPTH_WIDTH:0]  LEVEL_MIN   = (DEPTH_WIDTH + 1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(burst_bytes(BURST_LEN, DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] FRAME_END   = ADDR_WIDTH'(FRAME_BASE + FRAME_BYTES);

    rd_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  pending;
    logic [CNT_W-1:0]      reads_issued;
    logic [CNT_W-1:0]      beats_sent;
    logic                  rd_inflight;
    logic                  rd_en;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [1:0]            occ;
    logic                  pop;
    logic                  last_pop;

    camera_fifo_burst_reader_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (rd_inflight),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .count     (skid_count),
        .head      (skid_head)
    );

    assign pop      = bus.wr_data_valid & bus.wr_data_ready;
    assign last_pop = pop & (beats_sent == LAST_BEAT);
    assign addr_inc = addr + BURST_BYTES;
    // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle in steady state.
    assign occ      = skid_count + 2'(rd_inflight) - 2'(pop);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: if (!(frame_start || pending) && bus.fifo_rd_water_level >= LEVEL_MIN)
                         state_nxt = ST_CMD;
            ST_CMD:  if (bus.wr_cmd_ready) state_nxt = ST_DATA;
            ST_DATA: begin
                rd_en = (reads_issued < BURST_CNT) && !bus.fifo_rd_empty && (occ < 2'd2);
                if (last_pop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state        <= ST_IDLE;
            addr         <= BASE_ADDR;
            pending      <= 1'b0;
            reads_issued <= '0;
            beats_sent   <= '0;
            rd_inflight  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= rd_en;
            frame_done  <= 1'b0;
            if (state == ST_IDLE) begin
                reads_issued <= '0;
                beats_sent   <= '0;
                if (frame_start || pending) begin
                    addr    <= BASE_ADDR;
                    pending <= 1'b0;
                end
            end else begin
                // Restart requests mid-burst wait so the burst lands at its original address.
                if (frame_start) pending <= 1'b1;
                if (rd_en) reads_issued <= reads_issued + 1'b1;
                if (pop)   beats_sent   <= beats_sent + 1'b1;
                if (last_pop) begin
                    if (addr_inc == FRAME_END) begin
                        addr       <= BASE_ADDR;
                        frame_done <= 1'b1;
                    end else begin
                        addr <= addr_inc;
                    end
                end
            end
        end
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.wr_cmd_valid  = (state == ST_CMD);
    assign bus.wr_cmd_addr   = (state == ST_CMD) ? addr : '0;
    assign bus.wr_cmd_len    = (state == ST_CMD) ? CMD_LEN_W'(BURST_LEN - 1) : '0;
    assign bus.wr_data_valid = (skid_count != 2'd0);
    assign bus.wr_data       = skid_head;
    assign bus.wr_data_last  = (beats_sent == LAST_BEAT) && bus.wr_data_valid;
endmodule
